trig_debounce: RTL and testbench
================================

# trig_debounce

Debounce and edge-qualify stage for external trigger inputs, directly downstream of the level-mode synchronizer that brings asynchronous DIO/trigger pins into the ADC clock domain. It filters glitches from the synchronized level, then emits one-cycle trigger pulses on the selected edge. After each trigger it enforces a programmable hold-off and counts the qualifying edges that arrive during hold-off and are therefore dropped. The trigger output feeds the acquisition trigger mux and any pulse-mode synchronizer toward other domains; hold-off guarantees the minimum pulse spacing those synchronizers need.

## Interface
- CW, 20: width of debounce and hold-off counters/configs.
- MW, 16: width of missed-edge counter.

- clk_i  in  1  ADC clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- sig_i  in  1  level already synchronized to clk_i.
- cfg_en_i  in  1  1 = trigger generation enabled.
- cfg_edge_i  in  1  0 = rising, 1 = falling.
- cfg_deb_i  in  CW  debounce length N, in cycles.
- cfg_holdoff_i  in  CW  hold-off length H, in cycles.
- cnt_clr_i  in  1  synchronous clear of miss_cnt_o.
- lvl_o  out  1  debounced level.
- trig_o  out  1  one-cycle trigger pulse.
- miss_cnt_o  out  MW  dropped qualifying edges; saturating.

## Operation
- Debounce filter, evaluated every cycle:
  - sig_i == lvl_o: cnt <= 0.
  - else if cnt >= cfg_deb_i: lvl_o <= sig_i, cnt <= 0.
  - else: cnt <= cnt + 1.
  - cfg_deb_i is read live each cycle.
  - A level change held steady for N+1 cycles is accepted; any shorter excursion is rejected and resets cnt.
- Qualifying event (qe): the cycle in which lvl_o toggles in the selected direction.
- FSM states:
  - IDLE: cfg_en_i low. trig_o = 0, no counting.
  - ARMED
  - HOLDOFF
- Transitions:
  - Any state with cfg_en_i low goes to IDLE the next cycle; the hold-off count is discarded.
  - IDLE with cfg_en_i high goes to ARMED.
  - ARMED on qe: trig_o = 1 for one cycle and hcnt <= cfg_holdoff_i, sampled at trigger. If H = 0, stay ARMED; otherwise go to HOLDOFF.
  - HOLDOFF: hcnt decrements each cycle; when hcnt == 1, go to ARMED. A qe in HOLDOFF increments miss_cnt_o.
- miss_cnt_o saturates at 2^MW−1. cnt_clr_i wins over a simultaneous increment.
- lvl_o is tracked in every state, including IDLE.
- Edges during IDLE are neither triggered nor counted.

## Timing
- Reset values:
  - lvl_o = 0, trig_o = 0, miss_cnt_o = 0.
  - State = IDLE; internal counters = 0.
- Debounce latency: sig_i changes before edge k; lvl_o changes at edge k+N. N = 0 gives 1-cycle latency.
- trig_o is registered and asserts on the same edge as the qualifying lvl_o transition.
- With trigger at edge t:
  - edges t+1 … t+H are in hold-off;
  - earliest next trigger is at edge t+H+1;
  - minimum trigger spacing is H+1 cycles.
- A qe coinciding with the hcnt == 1 cycle is still counted as missed.
- Enabling takes one cycle: a qe on the edge where cfg_en_i first goes high is ignored.
- sig_i high at reset release produces a rising lvl_o after N+1 cycles, and a trigger if enabled and rising is selected.
- Reset asserted mid-hold-off or mid-debounce returns all state to reset values immediately.

## Structure
- Shared package/header holds:
  - FSM state encodings: ST_IDLE, ST_ARMED, ST_HOLDOFF.
  - Edge-select constants: EDGE_RISE = 0, EDGE_FALL = 1.
- Sub-module deb_filter (CW-parameterized) contains the debounce counter and the lvl_o register, and outputs a one-cycle toggle strobe with direction.
- Top level contains the FSM, the hold-off counter and the missed-edge counter.

## Test plan
- Debounce, N = 3, rising, H = 0, enabled. A 3-cycle high glitch → lvl_o stays 0, no trig_o. A 4-cycle high → lvl_o rises 3 cycles after the first high sample, with trig_o coincident for exactly one cycle.
- Hold-off, N = 0, H = 10, rising. Clean pulses spaced 4 cycles apart, 5 rising edges total → triggers on the 1st and 4th edges; miss_cnt_o = 3.
- Falling select, N = 0, H = 0. Square wave with period 6 → trig_o only on falling lvl_o transitions, spacing 6 cycles; miss_cnt_o = 0.
- Saturation/clear, MW = 4. Force 20 missed edges → miss_cnt_o holds 15. cnt_clr_i asserted in the same cycle as a miss → 0.
- Enable/reset mid-operation:
  - Drop cfg_en_i during HOLDOFF → no trig_o, no counting. Re-enable → the next edge triggers immediately (hold-off discarded).
  - Assert rst_i mid-debounce → all outputs 0 immediately, even without a clock edge.

Source files
------------

// File: rtl/trig_debounce_pkg.sv
// Shared definitions for the trigger debounce / edge-qualify stage:
// FSM state encoding and edge-select constants.
package trig_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/deb_filter.sv
// Debounce filter: accepts a level change only after it has been held for
// cfg_deb_i+1 consecutive samples; flags the cycle the accepted level flips.
module deb_filter #(
  parameter int CW = 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sig_i,
  input  logic [CW-1:0] cfg_deb_i,
  output logic          lvl_o,
  output logic          tgl_o,
  output logic          dir_o
);

  logic [CW-1:0] cnt_q;

  // Strobe is combinational so the downstream trigger register fires on the
  // same edge that updates lvl_o; dir_o is the level being accepted.
  assign tgl_o = (sig_i != lvl_o) && (cnt_q >= cfg_deb_i);
  assign dir_o = sig_i;

  // NOTE: non-blocking assignments for all registered state, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_o <= 1'b0;
    end else if (sig_i == lvl_o) begin
      cnt_q <= '0;
    end else if (tgl_o) begin
      lvl_o <= sig_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/trig_debounce.sv
// Trigger debounce and edge qualification with programmable hold-off and a
// saturating count of qualifying edges dropped during hold-off.
module trig_debounce
  import trig_debounce_pkg::*;
#(
  parameter int CW = 20,
  parameter int MW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sig_i,
  input  logic          cfg_en_i,
  input  logic          cfg_edge_i,
  input  logic [CW-1:0] cfg_deb_i,
  input  logic [CW-1:0] cfg_holdoff_i,
  input  logic          cnt_clr_i,
  output logic          lvl_o,
  output logic          trig_o,
  output logic [MW-1:0] miss_cnt_o
);

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q;
  logic [MW-1:0] miss_q;
  logic          trig_q;
  logic          tgl, dir, qe;
  logic          fire, miss_hit;

  deb_filter #(.CW(CW)) u_deb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sig_i     (sig_i),
    .cfg_deb_i (cfg_deb_i),
    .lvl_o     (lvl_o),
    .tgl_o     (tgl),
    .dir_o     (dir)
  );

  assign qe = tgl & (((cfg_edge_i == EDGE_RISE) & dir) |
                     ((cfg_edge_i == EDGE_FALL) & ~dir));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED:   if (qe && (cfg_holdoff_i != '0)) state_d = ST_HOLDOFF;
        ST_HOLDOFF: if (hcnt_q == CW'(1)) state_d = ST_ARMED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Disable wins over a coincident edge: nothing fires or counts that cycle.
  always_comb begin
    fire     = 1'b0;
    miss_hit = 1'b0;
    if (cfg_en_i && qe) begin
      fire     = (state_q == ST_ARMED);
      miss_hit = (state_q == ST_HOLDOFF);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q <= 1'b0;
      hcnt_q <= '0;
      miss_q <= '0;
    end else begin
      trig_q <= fire;
      if (fire)
        hcnt_q <= cfg_holdoff_i;
      else if ((state_q == ST_HOLDOFF) && (hcnt_q != '0))
        hcnt_q <= hcnt_q - 1'b1;
      if (cnt_clr_i)
        miss_q <= '0;
      else if (miss_hit && (miss_q != {MW{1'b1}}))
        miss_q <= miss_q + 1'b1;
    end
  end

  assign trig_o     = trig_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_trig_debounce.sv
// Bench for trig_debounce: directed scenarios plus random stimulus, all
// checked cycle by cycle against a time-based behavioural model.
module tb_trig_debounce;
  import trig_debounce_pkg::*;

  localparam int CW = 20;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig = 1'b0;
  logic          en = 1'b0;
  logic          edge_sel = EDGE_RISE;
  logic          clr = 1'b0;
  logic [CW-1:0] deb = '0;
  logic [CW-1:0] hold = '0;
  logic          lvl, trig;
  logic [MW-1:0] miss;

  trig_debounce #(.CW(CW), .MW(MW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sig_i         (sig),
    .cfg_en_i      (en),
    .cfg_edge_i    (edge_sel),
    .cfg_deb_i     (deb),
    .cfg_holdoff_i (hold),
    .cnt_clr_i     (clr),
    .lvl_o         (lvl),
    .trig_o        (trig),
    .miss_cnt_o    (miss)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int trig_seen = 0;

  // Model state: run length of disagreeing samples, time of last trigger.
  int cyc = 0;
  int m_run, m_miss, m_tlast, m_hlast;
  bit m_lvl, m_trig, m_en_prev, m_hvalid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_lvl = 0; m_trig = 0; m_miss = 0;
    m_en_prev = 0; m_hvalid = 0; m_tlast = 0; m_hlast = 0;
  endtask

  task automatic model_step();
    bit qe;
    qe = 0;
    cyc++;
    if (sig != m_lvl) begin
      m_run++;
      if (m_run > int'(deb)) begin
        m_lvl = sig;
        m_run = 0;
        qe = (edge_sel == EDGE_RISE) ? m_lvl : !m_lvl;
      end
    end else begin
      m_run = 0;
    end
    m_trig = 0;
    if (!en) m_hvalid = 0;
    if (qe && en && m_en_prev) begin
      if (m_hvalid && (cyc - m_tlast) <= m_hlast) begin
        if (m_miss < (1 << MW) - 1) m_miss++;
      end else begin
        m_trig = 1;
        m_tlast = cyc;
        m_hlast = int'(hold);
        m_hvalid = 1;
      end
    end
    if (clr) m_miss = 0;
    m_en_prev = en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (trig === 1'b1) trig_seen++;
    check("lvl", lvl, m_lvl);
    check("trig", trig, m_trig);
    check("miss", miss, m_miss);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    #3;
    check("rst_lvl", lvl, 0);
    check("rst_trig", trig, 0);
    check("rst_miss", miss, 0);
    #20 rst = 1'b0;

    // Debounce: N=3, rising, H=0
    deb = 3; hold = 0; edge_sel = EDGE_RISE; en = 1'b1;
    run(3);
    trig_seen = 0;
    sig = 1'b1; run(3);
    sig = 1'b0; run(4);
    check("s1_glitch_lvl", lvl, 0);
    sig = 1'b1; run(3);
    check("s1_lvl_pre", lvl, 0);
    run(1);
    check("s1_lvl_rise", lvl, 1);
    check("s1_trig_pulse", trig, 1);
    run(1);
    check("s1_trig_once", trig, 0);
    check("s1_ntrig", trig_seen, 1);
    sig = 1'b0; run(6);

    // Hold-off: N=0, H=10, 5 rising edges 4 cycles apart
    deb = 0; hold = 10;
    clr = 1'b1; run(1); clr = 1'b0;
    trig_seen = 0;
    for (int i = 0; i < 5; i++) begin
      sig = 1'b1; run(2);
      sig = 1'b0; run(2);
    end
    check("s2_miss", miss, 3);
    check("s2_ntrig", trig_seen, 2);
    run(12);

    // Falling select, period 6
    edge_sel = EDGE_FALL; hold = 0;
    clr = 1'b1; run(1); clr = 1'b0;
    trig_seen = 0;
    for (int i = 0; i < 4; i++) begin
      sig = 1'b1; run(3);
      sig = 1'b0; run(3);
    end
    check("s3_ntrig", trig_seen, 4);
    check("s3_miss", miss, 0);

    // Saturation and clear-vs-increment
    edge_sel = EDGE_RISE; hold = 1000;
    sig = 1'b1; run(2);
    sig = 1'b0; run(2);
    for (int i = 0; i < 20; i++) begin
      sig = 1'b1; run(1);
      sig = 1'b0; run(1);
    end
    check("s4_sat", miss, 15);
    sig = 1'b1; clr = 1'b1; run(1);
    clr = 1'b0;
    check("s4_clr_wins", miss, 0);
    sig = 1'b0; run(1);

    // Disable during hold-off, then re-enable
    sig = 1'b1; run(1);
    sig = 1'b0; run(1);
    check("s5_miss_hold", miss, 1);
    trig_seen = 0;
    en = 1'b0; run(2);
    sig = 1'b1; run(1);
    sig = 1'b0; run(1);
    check("s5_idle_ntrig", trig_seen, 0);
    check("s5_idle_miss", miss, 1);
    en = 1'b1; run(1);
    sig = 1'b1; run(1);
    check("s5_reen_trig", trig, 1);
    sig = 1'b0; run(1);
    en = 1'b0; run(1);
    en = 1'b1; run(1);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        deb = CW'($urandom_range(0, 4));
        hold = CW'($urandom_range(0, 12));
        edge_sel = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) sig = ~sig;
      if ($urandom_range(0, 63) == 0) en = ~en;
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 1'b0;

    // Asynchronous reset mid-debounce
    en = 1'b1; deb = 0; sig = 1'b1; run(2);
    deb = 5; sig = 1'b0; run(2);
    check("pre_rst_lvl", lvl, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_lvl", lvl, 0);
    check("async_rst_trig", trig, 0);
    check("async_rst_miss", miss, 0);
    model_reset();
    sig = 1'b1; edge_sel = EDGE_RISE; hold = 0;
    #4 rst = 1'b0;
    run(5);
    check("post_rst_lvl_pre", lvl, 0);
    run(1);
    check("post_rst_lvl_rise", lvl, 1);
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
